// File: rtl/intr_exc_entry.sv
// Exception/interrupt entry sequencer: latches the memory-stage trap or IRQ, then redirects fetch to the IVT vector.
// Optional overflow trap is enabled by defining CPU_EXC_OVF_EN.
module intr_exc_entry (
  input  logic        clk,
  input  logic        nrst,
  input  logic        i_core_stall,
  input  logic        i_irq,
  input  logic        i_sr_ie,
  input  logic [21:0] i_ivt_base,
  input  logic        i_valid_p3,
  input  logic [31:0] i_pc_p3,
  input  logic        i_exc_syscall_p3,
  input  logic        i_exc_break_p3,
  input  logic        i_exc_ovf_p3,
  output logic        o_drop_p1,
  output logic        o_drop_p2,
  output logic        o_drop_p3,
  output logic        o_jump,
  output logic [31:0] o_jump_addr,
  output logic        o_epc_we,
  output logic [31:0] o_epc,
  output logic        o_ie_save,
  output logic        o_irq_ack
);

  localparam int unsigned CAUSE_W = 3;
  localparam int unsigned BASE_W  = 22;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [CAUSE_W-1:0] CAUSE_NONE    = CAUSE_W'(0);
  localparam logic [CAUSE_W-1:0] CAUSE_IRQ     = CAUSE_W'(1);
  localparam logic [CAUSE_W-1:0] CAUSE_SYSCALL = CAUSE_W'(2);
  localparam logic [CAUSE_W-1:0] CAUSE_BREAK   = CAUSE_W'(3);
  localparam logic [CAUSE_W-1:0] CAUSE_OVF     = CAUSE_W'(4);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    IRQ_ACK  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [CAUSE_W-1:0]  cause_q;
  logic [ADDR_W-1:0]   epc_q;
  logic [BASE_W-1:0]   base_q;

  logic                ovf_evt;
  logic                irq_evt;
  logic [CAUSE_W-1:0]  cause_sel;
  logic                latch_en;

`ifdef CPU_EXC_OVF_EN
  assign ovf_evt = i_valid_p3 & i_exc_ovf_p3;
`else
  // Port kept for a stable interface; the trap source is tied off.
  logic unused_ovf;
  assign unused_ovf = i_exc_ovf_p3;
  assign ovf_evt    = 1'b0;
`endif

  assign irq_evt = i_valid_p3 & i_irq & i_sr_ie;

  // Fixed priority: BREAK > SYSCALL > OVERFLOW > IRQ.
  always_comb begin
    cause_sel = CAUSE_NONE;
    if (i_valid_p3 & i_exc_break_p3)        cause_sel = CAUSE_BREAK;
    else if (i_valid_p3 & i_exc_syscall_p3) cause_sel = CAUSE_SYSCALL;
    else if (ovf_evt)                       cause_sel = CAUSE_OVF;
    else if (irq_evt)                       cause_sel = CAUSE_IRQ;
  end

  // A stalled pipeline keeps presenting the event, so only latch when it advances.
  assign latch_en = (state == IDLE) & ~i_core_stall & (cause_sel != CAUSE_NONE);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cause_q <= CAUSE_NONE;
      epc_q   <= '0;
      base_q  <= '0;
    end else if (latch_en) begin
      cause_q <= cause_sel;
      epc_q   <= i_pc_p3;
      base_q  <= i_ivt_base;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (latch_en) state_nxt = REDIRECT;
      REDIRECT: if (!i_core_stall) state_nxt = (cause_q == CAUSE_IRQ) ? IRQ_ACK : IDLE;
      IRQ_ACK:  if (!i_irq) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Redirect strobes fire in the single unstalled REDIRECT cycle; data buses are zero otherwise.
  always_comb begin
    o_drop_p1   = 1'b0;
    o_drop_p2   = 1'b0;
    o_drop_p3   = 1'b0;
    o_jump      = 1'b0;
    o_jump_addr = '0;
    o_epc_we    = 1'b0;
    o_epc       = '0;
    o_ie_save   = 1'b0;
    o_irq_ack   = 1'b0;
    case (state)
      REDIRECT: begin
        if (!i_core_stall) begin
          o_drop_p1   = 1'b1;
          o_drop_p2   = 1'b1;
          o_drop_p3   = 1'b1;
          o_jump      = 1'b1;
          o_jump_addr = {base_q, 3'b000, cause_q, 4'b0000};
          o_epc_we    = 1'b1;
          o_epc       = epc_q;
          o_ie_save   = 1'b1;
        end
      end
      IRQ_ACK: o_irq_ack = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_intr_exc_entry.sv
// Directed self-checking bench for intr_exc_entry; honours CPU_EXC_OVF_EN like the RTL.
module tb_intr_exc_entry;

  logic        clk = 1'b0;
  logic        nrst;
  logic        i_core_stall, i_irq, i_sr_ie, i_valid_p3;
  logic [21:0] i_ivt_base;
  logic [31:0] i_pc_p3;
  logic        i_exc_syscall_p3, i_exc_break_p3, i_exc_ovf_p3;
  logic        o_drop_p1, o_drop_p2, o_drop_p3, o_jump, o_epc_we, o_ie_save, o_irq_ack;
  logic [31:0] o_jump_addr, o_epc;

  int n_vec = 0;
  int n_err = 0;

  intr_exc_entry dut (
    .clk(clk), .nrst(nrst), .i_core_stall(i_core_stall), .i_irq(i_irq), .i_sr_ie(i_sr_ie),
    .i_ivt_base(i_ivt_base), .i_valid_p3(i_valid_p3), .i_pc_p3(i_pc_p3),
    .i_exc_syscall_p3(i_exc_syscall_p3), .i_exc_break_p3(i_exc_break_p3),
    .i_exc_ovf_p3(i_exc_ovf_p3), .o_drop_p1(o_drop_p1), .o_drop_p2(o_drop_p2),
    .o_drop_p3(o_drop_p3), .o_jump(o_jump), .o_jump_addr(o_jump_addr), .o_epc_we(o_epc_we),
    .o_epc(o_epc), .o_ie_save(o_ie_save), .o_irq_ack(o_irq_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] strobes();
    return {25'd0, o_drop_p1, o_drop_p2, o_drop_p3, o_jump, o_epc_we, o_ie_save, o_irq_ack};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    #1;
    chk({tag, "_strb"}, strobes(), 32'h0);
    chk({tag, "_addr"}, o_jump_addr, 32'h0);
    chk({tag, "_epc"}, o_epc, 32'h0);
  endtask

  task automatic chk_pulse(input string tag, input logic [31:0] addr, input logic [31:0] epc);
    #1;
    chk({tag, "_strb"}, strobes(), 32'h7E);
    chk({tag, "_addr"}, o_jump_addr, addr);
    chk({tag, "_epc"}, o_epc, epc);
  endtask

  task automatic chk_ack(input string tag);
    #1;
    chk({tag, "_strb"}, strobes(), 32'h1);
    chk({tag, "_addr"}, o_jump_addr, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_events();
    i_valid_p3 = 1'b0; i_exc_syscall_p3 = 1'b0; i_exc_break_p3 = 1'b0; i_exc_ovf_p3 = 1'b0;
    i_pc_p3 = 32'h0;
  endtask

  initial begin
    nrst = 1'b0; i_core_stall = 1'b0; i_irq = 1'b0; i_sr_ie = 1'b0; i_ivt_base = 22'h0;
    clear_events();
    @(negedge clk);
    chk_quiet("reset");
    tick();
    nrst = 1'b1;
    tick();
    chk_quiet("idle");

    // IRQ with base 1, pc 0x100
    i_irq = 1'b1; i_sr_ie = 1'b1; i_valid_p3 = 1'b1; i_pc_p3 = 32'h100; i_ivt_base = 22'h1;
    tick();
    clear_events();
    chk_pulse("irq_pulse", 32'h410, 32'h100);
    tick();
    chk_ack("irq_ack0");
    tick();
    chk_ack("irq_ack1");
    i_irq = 1'b0;
    chk_ack("irq_ack_drop");
    tick();
    chk_quiet("irq_done");

    // SYSCALL beats IRQ
    i_irq = 1'b1; i_valid_p3 = 1'b1; i_exc_syscall_p3 = 1'b1; i_pc_p3 = 32'h200; i_ivt_base = 22'h0;
    tick();
    clear_events();
    chk_pulse("sys_pulse", 32'h20, 32'h200);
    tick();
    chk_quiet("sys_noack");
    i_irq = 1'b0;

    // IRQ masked by SR.IE, then by a bubble
    i_irq = 1'b1; i_sr_ie = 1'b0; i_valid_p3 = 1'b1; i_pc_p3 = 32'h104;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk_quiet("irq_masked");
    end
    i_sr_ie = 1'b1; i_valid_p3 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk_quiet("irq_bubble");
    end
    i_irq = 1'b0;

    // Event held under stall in IDLE is not latched
    i_core_stall = 1'b1; i_valid_p3 = 1'b1; i_exc_break_p3 = 1'b1; i_pc_p3 = 32'h500;
    tick();
    chk_quiet("idle_stall");
    clear_events(); i_core_stall = 1'b0;
    tick();
    chk_quiet("idle_stall_after");

    // BREAK stalled for three REDIRECT cycles
    i_valid_p3 = 1'b1; i_exc_break_p3 = 1'b1; i_pc_p3 = 32'h300;
    tick();
    clear_events(); i_core_stall = 1'b1;
    chk_quiet("brk_stall0");
    tick();
    chk_quiet("brk_stall1");
    tick();
    chk_quiet("brk_stall2");
    tick();
    i_core_stall = 1'b0;
    chk_pulse("brk_pulse", 32'h30, 32'h300);
    tick();
    chk_quiet("brk_done");

    // Priority with three causes; base latched at event time
    i_valid_p3 = 1'b1; i_exc_break_p3 = 1'b1; i_exc_syscall_p3 = 1'b1; i_exc_ovf_p3 = 1'b1;
    i_irq = 1'b1; i_pc_p3 = 32'hABC0; i_ivt_base = 22'h2;
    tick();
    clear_events(); i_irq = 1'b0; i_ivt_base = 22'h3FFFFF;
    chk_pulse("prio_pulse", 32'h830, 32'hABC0);
    tick();
    chk_quiet("prio_done");
    i_ivt_base = 22'h0;

    // Reset while in IRQ_ACK
    i_irq = 1'b1; i_valid_p3 = 1'b1; i_pc_p3 = 32'h108;
    tick();
    clear_events();
    chk_pulse("rst_ack_pulse", 32'h10, 32'h108);
    tick();
    chk_ack("rst_ack_pre");
    nrst = 1'b0;
    chk_quiet("rst_ack_now");
    tick();
    nrst = 1'b1;
    chk_quiet("rst_ack_held");
    tick();
    chk_quiet("rst_ack_after");
    i_irq = 1'b0;

    // Reset while in REDIRECT aborts the pulse
    i_valid_p3 = 1'b1; i_exc_syscall_p3 = 1'b1; i_pc_p3 = 32'h400;
    tick();
    clear_events();
    nrst = 1'b0;
    chk_quiet("rst_redir");
    tick();
    nrst = 1'b1;
    tick();
    chk_quiet("rst_redir_after");

    // Overflow trap
    i_valid_p3 = 1'b1; i_exc_ovf_p3 = 1'b1; i_pc_p3 = 32'h80;
    tick();
    clear_events();
`ifdef CPU_EXC_OVF_EN
    chk_pulse("ovf_pulse", 32'h40, 32'h80);
`else
    chk_quiet("ovf_ignored");
`endif
    tick();
    chk_quiet("ovf_done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
